// File: rtl/z_core_mem_arbiter.sv
// Arbiter sharing one single-port memory between the z_core control unit (M0)
// and the debug/DMA loader (M1). One access in flight at a time; ties are
// broken round-robin. The memory has a fixed read latency.
module z_core_mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1,
   parameter int RESET_PRIO  = 0
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic              m0_req_we,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [DATA_W-1:0] m0_req_wdata,
   output logic              m0_resp_valid,
   output logic [DATA_W-1:0] m0_resp_rdata,

   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic              m1_req_we,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [DATA_W-1:0] m1_req_wdata,
   output logic              m1_resp_valid,
   output logic [DATA_W-1:0] m1_resp_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy
);

   // state   | meaning
   // --------+-------------------------------------------------------------
   // S_IDLE  | no access in flight; arbitrate and accept one request
   // S_ISSUE | one-cycle mem_en strobe with the latched request
   // S_WAIT  | count down the memory latency, capture read data at zero
   // S_RESP  | one-cycle response pulse to the owning master
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic            LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              owner_q;
   logic              last_grant_q;
   logic              lat_we_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [DATA_W-1:0] lat_wdata_q;
   logic [DATA_W-1:0] resp_rdata_q;

   logic              sel_m1;
   logic              idle;
   logic              accept;
   logic              cnt_zero;

   assign idle     = (state_q == S_IDLE);
   assign accept   = idle && (m0_req_valid || m1_req_valid);
   assign cnt_zero = (cnt_q == '0);

   // Pick a master: a lone requester wins; on a tie, the one not granted last.
   always_comb begin
      sel_m1 = m1_req_valid;
      if (m0_req_valid && m1_req_valid) begin
         sel_m1 = ~last_grant_q;
      end
   end

   assign m0_req_ready = idle && m0_req_valid && !sel_m1;
   assign m1_req_ready = idle && m1_req_valid &&  sel_m1;

   // Next-state sequencing of a single access.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (cnt_zero) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, request latches, latency down-counter and response data register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= LAST_RST;
         lat_we_q     <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         resp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q      <= sel_m1;
            last_grant_q <= sel_m1;
            lat_we_q     <= sel_m1 ? m1_req_we    : m0_req_we;
            lat_addr_q   <= sel_m1 ? m1_req_addr  : m0_req_addr;
            lat_wdata_q  <= sel_m1 ? m1_req_wdata : m0_req_wdata;
         end
         // Reloaded on every issue, so the counter never needs to wrap.
         if (state_q == S_ISSUE) begin
            cnt_q <= CNT_LOAD;
         end else if (state_q == S_WAIT && !cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         // Writes return zero so a stale read value never leaks into an ack.
         if (state_q == S_WAIT && cnt_zero) begin
            resp_rdata_q <= lat_we_q ? '0 : mem_rdata;
         end
      end
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = (state_q == S_ISSUE) && lat_we_q;
   assign mem_addr  = lat_addr_q;
   assign mem_wdata = lat_wdata_q;

   assign m0_resp_valid = (state_q == S_RESP) && !owner_q;
   assign m1_resp_valid = (state_q == S_RESP) &&  owner_q;
   assign m0_resp_rdata = resp_rdata_q;
   assign m1_resp_rdata = resp_rdata_q;

   assign busy = !idle;

endmodule

// File: tb/tb_z_core_mem_arbiter.sv
// Bench for z_core_mem_arbiter: instance 0 uses MEM_LATENCY=1, instance 1
// uses MEM_LATENCY=4. A behavioural memory answers each instance; a
// scoreboard tracks accepted requests against issues and responses.
`timescale 1ns/1ps
module tb_z_core_mem_arbiter;
   localparam int LAT0 = 1;
   localparam int LAT1 = 4;

   logic        clk = 1'b0;
   logic        reset;

   logic        m0_req_valid [2];
   logic        m0_req_ready [2];
   logic        m0_req_we    [2];
   logic [31:0] m0_req_addr  [2];
   logic [31:0] m0_req_wdata [2];
   logic        m0_resp_valid[2];
   logic [31:0] m0_resp_rdata[2];
   logic        m1_req_valid [2];
   logic        m1_req_ready [2];
   logic        m1_req_we    [2];
   logic [31:0] m1_req_addr  [2];
   logic [31:0] m1_req_wdata [2];
   logic        m1_resp_valid[2];
   logic [31:0] m1_resp_rdata[2];
   logic        mem_en   [2];
   logic        mem_we   [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata[2];
   logic [31:0] mem_rdata[2];
   logic        busy     [2];

   int n_checks = 0;
   int n_err    = 0;
   int cyc_cnt  = 0;

   always #5 clk = ~clk;

   z_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT0), .RESET_PRIO(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .m0_req_valid(m0_req_valid[0]), .m0_req_ready(m0_req_ready[0]), .m0_req_we(m0_req_we[0]),
      .m0_req_addr(m0_req_addr[0]), .m0_req_wdata(m0_req_wdata[0]),
      .m0_resp_valid(m0_resp_valid[0]), .m0_resp_rdata(m0_resp_rdata[0]),
      .m1_req_valid(m1_req_valid[0]), .m1_req_ready(m1_req_ready[0]), .m1_req_we(m1_req_we[0]),
      .m1_req_addr(m1_req_addr[0]), .m1_req_wdata(m1_req_wdata[0]),
      .m1_resp_valid(m1_resp_valid[0]), .m1_resp_rdata(m1_resp_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   z_core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT1), .RESET_PRIO(0)) u_dut1 (
      .clk(clk), .reset(reset),
      .m0_req_valid(m0_req_valid[1]), .m0_req_ready(m0_req_ready[1]), .m0_req_we(m0_req_we[1]),
      .m0_req_addr(m0_req_addr[1]), .m0_req_wdata(m0_req_wdata[1]),
      .m0_resp_valid(m0_resp_valid[1]), .m0_resp_rdata(m0_resp_rdata[1]),
      .m1_req_valid(m1_req_valid[1]), .m1_req_ready(m1_req_ready[1]), .m1_req_we(m1_req_we[1]),
      .m1_req_addr(m1_req_addr[1]), .m1_req_wdata(m1_req_wdata[1]),
      .m1_resp_valid(m1_resp_valid[1]), .m1_resp_rdata(m1_resp_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   // Initial memory content; address 0x10 of instance 0 holds 0xDEADBEEF.
   function automatic logic [31:0] init_pat(input int k, input logic [7:0] idx);
      if (k == 0 && idx == 8'h04) return 32'hDEAD_BEEF;
      return {8'hC0, 7'd0, k[0], 8'h5A, idx};
   endfunction

   // Behavioural memories: read data appears exactly MEM_LATENCY cycles after
   // mem_en, and a poison value at every other time.
   bit   [31:0] mem_arr [2][256];
   bit          wr_flag [2][256];
   logic        pv [2][4];
   logic [31:0] pd [2][4];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_en[k] === 1'b1 && mem_we[k] === 1'b1) begin
            mem_arr[k][mem_addr[k][9:2]] <= mem_wdata[k];
            wr_flag[k][mem_addr[k][9:2]] <= 1'b1;
         end
         pv[k][0] <= (mem_en[k] === 1'b1) && (mem_we[k] === 1'b0);
         pd[k][0] <= wr_flag[k][mem_addr[k][9:2]] ? mem_arr[k][mem_addr[k][9:2]]
                                                  : init_pat(k, mem_addr[k][9:2]);
         for (int s = 1; s < 4; s++) begin
            pv[k][s] <= pv[k][s-1];
            pd[k][s] <= pd[k][s-1];
         end
      end
   end

   assign mem_rdata[0] = (pv[0][LAT0-1] === 1'b1) ? pd[0][LAT0-1] : 32'hBAD0_BAD0;
   assign mem_rdata[1] = (pv[1][LAT1-1] === 1'b1) ? pd[1][LAT1-1] : 32'hBAD0_BAD0;

   typedef struct { int k; logic we; logic [31:0] addr; logic [31:0] wdata; } iss_t;
   typedef struct { int k; int owner; logic [31:0] rdata; int cyc; } rsp_t;
   iss_t iq[$];
   rsp_t rq[$];
   bit [31:0] ref_mem [2][256];
   bit        ref_wr  [2][256];

   typedef struct {
      int n0; bit we0; logic [31:0] a0; logic [31:0] d0;
      int n1; bit we1; logic [31:0] a1; logic [31:0] d1;
      int first;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic mon_inst(input int k);
      int lat, g, fi;
      logic we;
      logic [31:0] a, d, e;
      iss_t ie;
      rsp_t re;
      lat = (k == 0) ? LAT0 : LAT1;
      chk($sformatf("i%0d_ready_excl", k), {31'd0, m0_req_ready[k] && m1_req_ready[k]}, 0);
      chk($sformatf("i%0d_ready_busy", k), {31'd0, busy[k] && (m0_req_ready[k] || m1_req_ready[k])}, 0);
      chk($sformatf("i%0d_resp_excl", k), {31'd0, m0_resp_valid[k] && m1_resp_valid[k]}, 0);
      g = -1;
      if (m0_req_valid[k] && m0_req_ready[k]) g = 0;
      if (m1_req_valid[k] && m1_req_ready[k]) g = 1;
      if (g >= 0) begin
         we = (g == 1) ? m1_req_we[k]    : m0_req_we[k];
         a  = (g == 1) ? m1_req_addr[k]  : m0_req_addr[k];
         d  = (g == 1) ? m1_req_wdata[k] : m0_req_wdata[k];
         e  = we ? 32'h0 : (ref_wr[k][a[9:2]] ? ref_mem[k][a[9:2]] : init_pat(k, a[9:2]));
         if (we) begin
            ref_mem[k][a[9:2]] = d;
            ref_wr[k][a[9:2]]  = 1'b1;
         end
         ie.k = k; ie.we = we; ie.addr = a; ie.wdata = d;
         re.k = k; re.owner = g; re.rdata = e; re.cyc = cyc_cnt;
         iq.push_back(ie);
         rq.push_back(re);
      end
      if (mem_en[k] === 1'b1) begin
         fi = -1;
         for (int i = 0; i < iq.size(); i++) if (fi < 0 && iq[i].k == k) fi = i;
         if (fi < 0) chk($sformatf("i%0d_spurious_mem_en", k), 1, 0);
         else begin
            ie = iq[fi];
            iq.delete(fi);
            chk($sformatf("i%0d_mem_we", k), {31'd0, mem_we[k]}, {31'd0, ie.we});
            chk($sformatf("i%0d_mem_addr", k), mem_addr[k], ie.addr);
            if (ie.we) chk($sformatf("i%0d_mem_wdata", k), mem_wdata[k], ie.wdata);
         end
      end
      if (m0_resp_valid[k] === 1'b1 || m1_resp_valid[k] === 1'b1) begin
         fi = -1;
         for (int i = 0; i < rq.size(); i++) if (fi < 0 && rq[i].k == k) fi = i;
         if (fi < 0) chk($sformatf("i%0d_spurious_resp", k), 1, 0);
         else begin
            re = rq[fi];
            rq.delete(fi);
            g = (m1_resp_valid[k] === 1'b1) ? 1 : 0;
            chk($sformatf("i%0d_resp_owner", k), g, re.owner);
            chk($sformatf("i%0d_resp_rdata", k), (g == 1) ? m1_resp_rdata[k] : m0_resp_rdata[k], re.rdata);
            chk($sformatf("i%0d_resp_latency", k), cyc_cnt - re.cyc, lat + 2);
         end
      end
   endtask

   task automatic monitor_loop();
      forever begin
         @(negedge clk);
         cyc_cnt++;
         if (reset) begin
            iq.delete();
            rq.delete();
         end else begin
            for (int k = 0; k < 2; k++) mon_inst(k);
         end
      end
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         m0_req_valid[k] = 1'b0; m0_req_we[k] = 1'b0; m0_req_addr[k] = '0; m0_req_wdata[k] = '0;
         m1_req_valid[k] = 1'b0; m1_req_we[k] = 1'b0; m1_req_addr[k] = '0; m1_req_wdata[k] = '0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Applies one table record to instance 0, checking every grant decision.
   task automatic run_vec(input int vi);
      vec_t v;
      int rem0, rem1, i0, i1, lastg, lastc, cyc, g, eg;
      v = vecs[vi];
      rem0 = v.n0; rem1 = v.n1; i0 = 0; i1 = 0; lastg = -1; lastc = -1; cyc = 0;
      @(posedge clk); #1;
      while ((rem0 > 0 || rem1 > 0) && cyc < 300) begin
         m0_req_valid[0] = (rem0 > 0); m0_req_we[0] = v.we0;
         m0_req_addr[0]  = v.a0 + 32'(4 * i0); m0_req_wdata[0] = v.d0 + 32'(i0);
         m1_req_valid[0] = (rem1 > 0); m1_req_we[0] = v.we1;
         m1_req_addr[0]  = v.a1 + 32'(4 * i1); m1_req_wdata[0] = v.d1 + 32'(i1);
         @(negedge clk);
         g = -1;
         if (m0_req_valid[0] && m0_req_ready[0]) g = 0;
         else if (m1_req_valid[0] && m1_req_ready[0]) g = 1;
         if (g >= 0) begin
            if (rem0 > 0 && rem1 > 0) eg = (lastg < 0) ? v.first : 1 - lastg;
            else eg = (rem0 > 0) ? 0 : 1;
            chk($sformatf("v%0d_grant", vi), g, eg);
            if (lastc >= 0) chk($sformatf("v%0d_grant_gap", vi), cyc - lastc, LAT0 + 3);
            lastg = g; lastc = cyc;
            if (g == 0) begin rem0--; i0++; end
            else begin rem1--; i1++; end
         end
         @(posedge clk); #1;
         cyc++;
      end
      m0_req_valid[0] = 1'b0;
      m1_req_valid[0] = 1'b0;
      chk($sformatf("v%0d_all_granted", vi), rem0 + rem1, 0);
      cyc = 0;
      while (rq.size() != 0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("v%0d_drained", vi), rq.size(), 0);
   endtask

   initial begin
      logic [31:0] rd;
      int got;
      reset = 1'b1;
      idle_inputs();
      fork monitor_loop(); join_none

      vecs[0] = '{1, 1'b0, 32'h40,  32'h0,         1, 1'b0, 32'h44,  32'h0,         0};
      vecs[1] = '{1, 1'b0, 32'h48,  32'h0,         1, 1'b0, 32'h4C,  32'h0,         0};
      vecs[2] = '{0, 1'b0, 32'h0,   32'h0,         1, 1'b1, 32'h100, 32'h1234_5678, 1};
      vecs[3] = '{1, 1'b0, 32'h100, 32'h0,         0, 1'b0, 32'h0,   32'h0,         0};
      vecs[4] = '{1, 1'b1, 32'h80,  32'hCAFE_0000, 1, 1'b0, 32'h84,  32'h0,         1};
      vecs[5] = '{0, 1'b0, 32'h0,   32'h0,         2, 1'b0, 32'h80,  32'h0,         1};
      vecs[6] = '{6, 1'b0, 32'h200, 32'h0,         5, 1'b0, 32'h300, 32'h0,         0};

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst%0d_ready", k), {30'd0, m0_req_ready[k], m1_req_ready[k]}, 0);
         chk($sformatf("rst%0d_resp_valid", k), {30'd0, m0_resp_valid[k], m1_resp_valid[k]}, 0);
         chk($sformatf("rst%0d_mem_ctl", k), {29'd0, mem_en[k], mem_we[k], busy[k]}, 0);
         chk($sformatf("rst%0d_mem_addr", k), mem_addr[k], 0);
         chk($sformatf("rst%0d_mem_wdata", k), mem_wdata[k], 0);
         chk($sformatf("rst%0d_rdata", k), m0_resp_rdata[k] | m1_resp_rdata[k], 0);
      end
      @(posedge clk); #1 reset = 1'b0;

      // M0 read of 0x10 at latency 1: ready T, mem_en T+1, response T+3.
      m0_req_valid[0] = 1'b1; m0_req_we[0] = 1'b0; m0_req_addr[0] = 32'h10;
      @(negedge clk);
      chk("t1_m0_ready", {31'd0, m0_req_ready[0]}, 1);
      chk("t1_m1_ready", {31'd0, m1_req_ready[0]}, 0);
      @(posedge clk); #1 m0_req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_mem_en_t1", {31'd0, mem_en[0]}, 1);
      chk("t1_mem_addr", mem_addr[0], 32'h10);
      chk("t1_mem_we", {31'd0, mem_we[0]}, 0);
      @(negedge clk);
      chk("t1_mem_en_t2", {31'd0, mem_en[0]}, 0);
      chk("t1_resp_early", {31'd0, m0_resp_valid[0]}, 0);
      @(negedge clk);
      chk("t1_resp_valid", {31'd0, m0_resp_valid[0]}, 1);
      chk("t1_resp_rdata", m0_resp_rdata[0], 32'hDEAD_BEEF);
      chk("t1_m1_resp", {31'd0, m1_resp_valid[0]}, 0);
      @(negedge clk);
      chk("t1_resp_once", {31'd0, m0_resp_valid[0]}, 0);
      chk("t1_idle", {31'd0, busy[0]}, 0);

      // Latency 4, valid held throughout: per-cycle busy/ready/mem_en/resp.
      @(posedge clk); #1;
      m0_req_valid[1] = 1'b1; m0_req_we[1] = 1'b0; m0_req_addr[1] = 32'h20;
      @(negedge clk);
      chk("t4_ready_t0", {31'd0, m0_req_ready[1]}, 1);
      chk("t4_busy_t0", {31'd0, busy[1]}, 0);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         if (c == 7) m0_req_valid[1] = 1'b0;
         @(negedge clk);
         chk($sformatf("t4_busy_c%0d", c), {31'd0, busy[1]}, {31'd0, c <= 6});
         chk($sformatf("t4_ready_c%0d", c), {31'd0, m0_req_ready[1]}, 0);
         chk($sformatf("t4_mem_en_c%0d", c), {31'd0, mem_en[1]}, {31'd0, c == 1});
         chk($sformatf("t4_resp_c%0d", c), {31'd0, m0_resp_valid[1]}, {31'd0, c == 6});
         if (c == 6) chk("t4_rdata", m0_resp_rdata[1], init_pat(1, 8'h08));
      end

      // Reset while in WAIT aborts the access silently.
      @(posedge clk); #1;
      m0_req_valid[1] = 1'b1; m0_req_we[1] = 1'b0; m0_req_addr[1] = 32'h28;
      @(negedge clk);
      chk("t5_ready", {31'd0, m0_req_ready[1]}, 1);
      @(posedge clk); #1 m0_req_valid[1] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_in_wait", {31'd0, busy[1]}, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_idle_after_rst", {31'd0, busy[1]}, 0);
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("t5_quiet_c%0d", c), {29'd0, mem_en[1], m0_resp_valid[1], m1_resp_valid[1]}, 0);
      end
      @(posedge clk); #1;
      m0_req_valid[1] = 1'b1; m0_req_we[1] = 1'b0; m0_req_addr[1] = 32'h30;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(negedge clk);
         if (m0_req_ready[1] === 1'b1) got = 1;
         @(posedge clk); #1;
      end
      m0_req_valid[1] = 1'b0;
      chk("t5_accept", got, 1);
      got = 0; rd = '0;
      for (int c = 0; c < 12 && got == 0; c++) begin
         @(negedge clk);
         if (m0_resp_valid[1] === 1'b1) begin
            got = 1;
            rd = m0_resp_rdata[1];
         end
      end
      chk("t5_resp_seen", got, 1);
      chk("t5_resp_rdata", rd, init_pat(1, 8'h0C));

      // Table-driven arbitration sequences, starting from a fresh reset.
      do_reset();
      for (int vi = 0; vi < 7; vi++) run_vec(vi);

      repeat (6) @(negedge clk);
      chk("end_issue_queue", iq.size(), 0);
      chk("end_resp_queue", rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
